// File: rtl/tmds_pkg.sv
// TMDS shared definitions: control tokens, alignment states, decode helpers.
// Shared between the receive decoder and the transmit encoder.
package tmds_pkg;

  localparam int CTRL_W = 2;
  localparam int DATA_W = 8;
  localparam int SYM_W  = 10;

  localparam logic [SYM_W-1:0] TOK_CD0 = 10'b1101010100;
  localparam logic [SYM_W-1:0] TOK_CD1 = 10'b0010101011;
  localparam logic [SYM_W-1:0] TOK_CD2 = 10'b0101010100;
  localparam logic [SYM_W-1:0] TOK_CD3 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH,
    SLIP,
    LOCKED
  } state_e;

  function automatic logic is_token(
    input logic [SYM_W-1:0] s
  );
    return (s == TOK_CD0) || (s == TOK_CD1) ||
           (s == TOK_CD2) || (s == TOK_CD3);
  endfunction

  function automatic logic [CTRL_W-1:0] token_cd(
    input logic [SYM_W-1:0] s
  );
    logic [CTRL_W-1:0] cd;
    cd = '0;
    unique case (1'b1)
      (s == TOK_CD1): cd = 2'b01;
      (s == TOK_CD2): cd = 2'b10;
      (s == TOK_CD3): cd = 2'b11;
      default:        cd = 2'b00;
    endcase
    return cd;
  endfunction

  function automatic logic [DATA_W-1:0] decode_data(
    input logic [SYM_W-1:0] s
  );
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d    = '0;
    d[0] = q[0];
    for (int i = 1; i < DATA_W; i++)
      d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  function automatic logic [3:0] ones(
    input logic [SYM_W-1:0] s
  );
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < SYM_W; i++)
      n = n + {3'b0, s[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_align_fsm.sv
// Word-alignment FSM: hunts for control-token runs, requests bit-slips,
// and tracks loss of lock when control periods stop arriving.
module tmds_align_fsm
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT = 8,
  parameter int WINDOW     = 1024,
  parameter int SLIP_WAIT  = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sym_valid,
  input  logic is_ctrl,
  output logic accept,
  output logic locked,
  output logic bitslip
);

  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int SW = $clog2(SLIP_WAIT + 1);

  state_e        state_q;
  logic [RW-1:0] run_q;
  logic [WW-1:0] win_q;
  logic [SW-1:0] slip_q;
  logic          locked_q;
  logic          bitslip_q;

  logic [RW-1:0] run_inc;
  logic [WW-1:0] win_inc;
  logic          lock_hit;
  logic          win_hit;

  assign run_inc = (run_q == RW'(LOCK_COUNT)) ?
                   run_q : run_q + 1'b1;
  assign win_inc = (win_q == WW'(WINDOW)) ?
                   win_q : win_q + 1'b1;

  assign lock_hit = (state_q == SEARCH) && sym_valid &&
                    is_ctrl && (run_inc == RW'(LOCK_COUNT));
  // In LOCKED a control token restarts the window, so it never expires
  assign win_hit  = sym_valid && (win_inc == WW'(WINDOW)) &&
                    ((state_q == SEARCH) || !is_ctrl);

  assign accept = sym_valid &&
                  (lock_hit ||
                   ((state_q == LOCKED) && !win_hit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEARCH;
      run_q     <= '0;
      win_q     <= '0;
      slip_q    <= '0;
      locked_q  <= 1'b0;
      bitslip_q <= 1'b0;
    end else begin
      bitslip_q <= 1'b0;
      unique case (state_q)
        SEARCH: begin
          if (sym_valid) begin
            if (lock_hit) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              run_q    <= '0;
              win_q    <= '0;
            end else if (win_hit) begin
              state_q   <= SLIP;
              bitslip_q <= 1'b1;
              slip_q    <= '0;
              run_q     <= '0;
              win_q     <= '0;
            end else begin
              win_q <= win_inc;
              run_q <= is_ctrl ? run_inc : '0;
            end
          end
        end
        SLIP: begin
          if (slip_q == SW'(SLIP_WAIT - 1)) begin
            state_q <= SEARCH;
            slip_q  <= '0;
            run_q   <= '0;
            win_q   <= '0;
          end else begin
            slip_q <= slip_q + 1'b1;
          end
        end
        LOCKED: begin
          if (sym_valid) begin
            if (is_ctrl) begin
              win_q <= '0;
            end else if (win_hit) begin
              state_q  <= SEARCH;
              locked_q <= 1'b0;
              win_q    <= '0;
              run_q    <= '0;
            end else begin
              win_q <= win_inc;
            end
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign locked  = locked_q;
  assign bitslip = bitslip_q;

endmodule

// File: rtl/tmds_decoder.sv
// TMDS receive channel decoder with word alignment and lock gating.
// Define TMDS_DISP_CHECK_EN to enable the running-disparity checker.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT = 8,
  parameter int WINDOW     = 1024,
  parameter int SLIP_WAIT  = 16
`ifdef TMDS_DISP_CHECK_EN
  ,
  parameter int DISP_LIMIT = 10
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SYM_W-1:0]  sym_in,
  input  logic              sym_valid,
  output logic              bitslip,
  output logic              locked,
  output logic [DATA_W-1:0] VD,
  output logic [CTRL_W-1:0] CD,
  output logic              VDE,
  output logic              out_valid,
  output logic              disp_err
);

  logic is_ctrl;
  logic accept;
  logic hold;

  logic [DATA_W-1:0] vd_q, vd_d;
  logic [CTRL_W-1:0] cd_q, cd_d;
  logic              vde_q, vde_d;
  logic              ov_q;

  assign is_ctrl = is_token(sym_in);
  // Stay put while locked and idle; everything else zeroes
  assign hold    = locked && !sym_valid;

  tmds_align_fsm #(
    .LOCK_COUNT (LOCK_COUNT),
    .WINDOW     (WINDOW),
    .SLIP_WAIT  (SLIP_WAIT)
  ) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .sym_valid (sym_valid),
    .is_ctrl   (is_ctrl),
    .accept    (accept),
    .locked    (locked),
    .bitslip   (bitslip)
  );

  always_comb begin
    vd_d  = vd_q;
    cd_d  = cd_q;
    vde_d = vde_q;
    if (accept) begin
      if (is_ctrl) begin
        vd_d  = '0;
        cd_d  = token_cd(sym_in);
        vde_d = 1'b0;
      end else begin
        vd_d  = decode_data(sym_in);
        vde_d = 1'b1;
      end
    end else if (!hold) begin
      vd_d  = '0;
      cd_d  = '0;
      vde_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vd_q  <= '0;
      cd_q  <= '0;
      vde_q <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      vd_q  <= vd_d;
      cd_q  <= cd_d;
      vde_q <= vde_d;
      ov_q  <= accept;
    end
  end

  assign VD        = vd_q;
  assign CD        = cd_q;
  assign VDE       = vde_q;
  assign out_valid = ov_q;

`ifdef TMDS_DISP_CHECK_EN
  localparam logic signed [6:0] LIM = 7'(DISP_LIMIT);

  logic signed [5:0] disp_q, disp_d;
  logic signed [6:0] delta;
  logic signed [6:0] sum;
  logic              derr_q, derr_d;

  assign delta = $signed({2'b0, ones(sym_in), 1'b0}) - 7'sd10;
  assign sum   = {disp_q[5], disp_q} + delta;

  always_comb begin
    disp_d = disp_q;
    derr_d = 1'b0;
    if (accept) begin
      if (is_ctrl) begin
        disp_d = '0;
      end else if ((sum > LIM) || (sum < -LIM)) begin
        disp_d = '0;
        derr_d = 1'b1;
      end else begin
        disp_d = sum[5:0];
      end
    end else if (!hold) begin
      disp_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= '0;
      derr_q <= 1'b0;
    end else begin
      disp_q <= disp_d;
      derr_q <= derr_d;
    end
  end

  assign disp_err = derr_q;
`else
  assign disp_err = 1'b0;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: lock, decode, slip, loss of lock.
// Disparity checks follow TMDS_DISP_CHECK_EN.
module tb_tmds_decoder;
  import tmds_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [9:0] sym_in;
  logic       sym_valid;
  logic       bitslip;
  logic       locked;
  logic [7:0] VD;
  logic [1:0] CD;
  logic       VDE;
  logic       out_valid;
  logic       disp_err;

  int n_chk;
  int n_fail;
  int slips;
  int ovs;

  localparam logic [9:0] D_00 = 10'b0100000000;
  localparam logic [9:0] D_FF = 10'b0101010101;
  localparam logic [9:0] D_FE = 10'b1011111111;
  localparam logic [9:0] D_P6 = 10'b0011111111;

  tmds_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .bitslip   (bitslip),
    .locked    (locked),
    .VD        (VD),
    .CD        (CD),
    .VDE       (VDE),
    .out_valid (out_valid),
    .disp_err  (disp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bitslip === 1'b1) slips++;
    if (out_valid === 1'b1) ovs++;
  end

  task automatic check_eq(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step(
    input logic [9:0] s,
    input logic       v
  );
    @(negedge clk);
    sym_in    = s;
    sym_valid = v;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    sym_in    = '0;
    sym_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic lock_up();
    for (int i = 0; i < 8; i++) step(TOK_CD0, 1'b1);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    slips     = 0;
    ovs       = 0;
    rst_n     = 1'b0;
    sym_in    = '0;
    sym_valid = 1'b0;
    do_reset();

    check_eq("rst_locked", locked, 0);
    check_eq("rst_bitslip", bitslip, 0);
    check_eq("rst_ov", out_valid, 0);
    check_eq("rst_vd", VD, 0);
    check_eq("rst_cd", CD, 0);
    check_eq("rst_vde", VDE, 0);
    check_eq("rst_derr", disp_err, 0);

    for (int i = 0; i < 7; i++) step(TOK_CD0, 1'b1);
    check_eq("pre_lock", locked, 0);
    check_eq("pre_lock_ov", out_valid, 0);
    step(TOK_CD0, 1'b1);
    check_eq("lock", locked, 1);
    check_eq("lock_ov", out_valid, 1);
    check_eq("lock_vde", VDE, 0);
    check_eq("lock_cd", CD, 0);

    step(D_P6, 1'b1);
    check_eq("disp1_vd", VD, 8'hFF);
    check_eq("disp1", disp_err, 0);
    step(D_P6, 1'b1);
`ifdef TMDS_DISP_CHECK_EN
    check_eq("disp2", disp_err, 1);
`else
    check_eq("disp2", disp_err, 0);
`endif
    step(D_P6, 1'b1);
    check_eq("disp3", disp_err, 0);

    step(TOK_CD1, 1'b1);
    check_eq("tok1_cd", CD, 2'b01);
    check_eq("tok1_vde", VDE, 0);
    check_eq("tok1_vd", VD, 0);
    step(D_00, 1'b1);
    check_eq("d00_vd", VD, 8'h00);
    check_eq("d00_vde", VDE, 1);
    check_eq("d00_cd", CD, 2'b01);
    step(D_FF, 1'b1);
    check_eq("dff_vd", VD, 8'hFF);
    step(D_FE, 1'b1);
    check_eq("dfe_vd", VD, 8'hFE);
    check_eq("dfe_ov", out_valid, 1);
    step(TOK_CD3, 1'b1);
    check_eq("tok3_cd", CD, 2'b11);
    step(TOK_CD2, 1'b1);
    check_eq("tok2_cd", CD, 2'b10);
    step(D_00, 1'b0);
    check_eq("idle_ov", out_valid, 0);
    check_eq("idle_lock", locked, 1);

    for (int i = 0; i < 1023; i++) step(D_00, 1'b1);
    check_eq("win_hold", locked, 1);
    check_eq("win_hold_ov", out_valid, 1);
    step(D_00, 1'b1);
    check_eq("win_drop", locked, 0);
    check_eq("win_drop_ov", out_valid, 0);
    step(D_00, 1'b1);
    check_eq("win_after_ov", out_valid, 0);
    check_eq("win_no_slip", slips, 0);

    do_reset();
    ovs   = 0;
    slips = 0;
    for (int i = 0; i < 1023; i++) step(D_00, 1'b1);
    check_eq("srch_no_slip", bitslip, 0);
    step(D_00, 1'b1);
    check_eq("slip_pulse", bitslip, 1);
    step(TOK_CD0, 1'b1);
    check_eq("slip_1clk", bitslip, 0);
    for (int i = 0; i < 15; i++) step(TOK_CD0, 1'b1);
    check_eq("slip_ignore", locked, 0);
    for (int i = 0; i < 7; i++) step(TOK_CD0, 1'b1);
    check_eq("slip_pre", locked, 0);
    step(TOK_CD0, 1'b1);
    check_eq("slip_relock", locked, 1);
    check_eq("slip_count", slips, 1);
    check_eq("slip_ov_cnt", ovs, 1);

    do_reset();
    for (int i = 0; i < 7; i++) step(TOK_CD0, 1'b1);
    step(D_00, 1'b1);
    for (int i = 0; i < 7; i++) step(TOK_CD0, 1'b1);
    check_eq("brk_15", locked, 0);
    step(TOK_CD0, 1'b1);
    check_eq("brk_16", locked, 1);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("async_lock", locked, 0);
    check_eq("async_ov", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
